data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Shares the single-port 16-bit data memory between two requesters: port 0 (CPU load/store) and port 1 (debug/DMA).
//  Round-robin arbitration with a per-port req/ack handshake.
//  Drives the memory's address, write-data, MemWrite and MemRead lines.
//  Returns the big-endian 16-bit read word ({mem[a], mem[a+1]}) and a range-error flag.
// PARAMETERS
//  MEM_BYTES  128  byte depth of the attached data memory; legal addresses are 0 .. MEM_BYTES-2
//  AW         16   address width
//  DW         16   data width
// PORTS
//  Clock        in   1   single clock, all state updates on posedge
//  Reset        in   1   synchronous, active-high
//  Req0/Req1    in   1   request; held high until the matching Ack
//  Wr0/Wr1      in   1   1 = store, 0 = load; sampled with the request at grant
//  Addr0/Addr1  in   AW  byte address; sampled at grant
//  WData0/1     in   DW  store data; sampled at grant
//  Ack0/Ack1    out  1   one-cycle completion pulse
//  RData0/1     out  DW  load result; valid while Ack is high, held until the port's next Ack
//  Err0/Err1    out  1   one-cycle pulse coincident with Ack when the address is out of range
//  MemAdresa    out  AW  to memory Adresa
//  MemWData     out  DW  to memory WriteData
//  MemWrite     out  1   to memory MemWrite
//  MemRead      out  1   to memory MemRead
//  MemRData     in   DW  from memory ReadData (combinational read)
// BEHAVIOUR
//  Reset: every output is 0, FSM = IDLE, last_grant = 1 (port 0 wins the first contest).
//  FSM states:
//   - IDLE: if any Req, choose a winner and latch the winner's Wr/Addr/WData into txn regs -> ACCESS.
//   - ACCESS: one cycle; -> RESP.
//   - RESP: one cycle; -> IDLE.
//  Arbitration:
//   - Only one Req high: that port wins.
//   - Both high: the port != last_grant wins.
//   - last_grant updates on entering ACCESS.
//  ACCESS cycle:
//   - MemAdresa = txn addr; MemWData = txn data.
//   - MemWrite = txn wr & in_range; MemRead = ~txn wr & in_range.
//   - Store: the memory commits at the posedge that ends ACCESS.
//   - Load: MemRData is captured into the winner's RData at that posedge.
//  RESP cycle:
//   - Ack of the winner = 1; Err = ~in_range.
//   - Memory strobes are 0; MemAdresa/MemWData hold their last value.
//  in_range = (txn addr <= MEM_BYTES-2), computed at AW bits.
//   - Out of range: no memory strobe, RData unchanged, Err pulses with Ack.
//  Odd addresses are legal; there is no alignment check.
//  Latency: Req seen high in IDLE at edge N -> Ack high in cycle N+2.
//   - Throughput is at most 1 transaction per 3 cycles.
//   - A back-to-back Req is re-arbitrated in IDLE, so an alternating grant is guaranteed under contention.
//  Boundaries:
//   - Req dropped during ACCESS/RESP: the transaction still completes and Ack still pulses.
//   - Changing Addr/WData after grant: no effect on the transaction.
//   - Reset asserted in ACCESS: next cycle is IDLE with all strobes 0; no Ack is issued.
//     A store is still committed only if the Reset edge coincides with the memory write edge.
//   - Both Ack signals are never high in the same cycle; MemWrite and MemRead are never both high.
// STRUCTURE
//  Shared package dmem_pkg:
//   - State encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2.
//   - MEM_BYTES default, AW, DW.
//  Sub-module rr_arbiter2: combinational 2-way round-robin pick from {Req1,Req0} and last_grant.
//  Everything else (FSM, txn regs, RData regs) is in this module.
// TESTING (bench instantiates this block with DataMemory, memory file pre-zeroed)
//  - Port 0 store 0xBEEF @ 0x0010, then load @ 0x0010 -> Ack0 at +2 cycles each; RData0=0xBEEF; mem[0x10]=0xBE, mem[0x11]=0xEF.
//  - Req0 and Req1 high together, held 4 transactions -> grant order 0,1,0,1; no cycle with Ack0 & Ack1.
//  - Port 1 load @ 0x007E (126) -> OK, Err1=0; load @ 0x007F -> Ack1 with Err1=1, MemRead never asserted, RData1 unchanged.
//  - Odd address store 0x1234 @ 0x0005 -> mem[5]=0x12, mem[6]=0x34; load returns 0x1234.
//  - Reset pulsed during ACCESS of a port 0 load -> no Ack0; FSM IDLE; all outputs 0 next cycle.
//  - Req1 dropped during ACCESS of a store 0x00AA @ 0x20 -> Ack1 still pulses; the memory holds 0x00AA.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: bus widths, default memory
// depth and FSM state encoding.
package dmem_pkg;

  localparam int DMEM_MEM_BYTES = 128;
  localparam int DMEM_AW        = 16;
  localparam int DMEM_DW        = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, under contention
// the port that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port byte-addressed data memory between a CPU port (0) and a
// debug/DMA port (1); big-endian 16-bit words, one transaction per 3 cycles.
module data_memory_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = DMEM_MEM_BYTES,
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          Wr0,
  input  logic          Wr1,
  input  logic [AW-1:0] Addr0,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] WData0,
  input  logic [DW-1:0] WData1,
  output logic          Ack0,
  output logic          Ack1,
  output logic [DW-1:0] RData0,
  output logic [DW-1:0] RData1,
  output logic          Err0,
  output logic          Err1,
  output logic [AW-1:0] MemAdresa,
  output logic [DW-1:0] MemWData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] MemRData
);

  state_t          state_reg, state_next;
  logic            last_grant_reg, last_grant_next;
  logic            grant_en;
  logic            arb_valid, arb_grant;
  logic            txn_port_reg, txn_wr_reg;
  logic [AW-1:0]   txn_addr_reg;
  logic [DW-1:0]   txn_data_reg;
  logic [DW-1:0]   rdata0_reg, rdata1_reg;
  logic            in_range, in_access, in_resp;

  rr_arbiter2 u_arb (
    .req        ({Req1, Req0}),
    .last_grant (last_grant_reg),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  // A word occupies addr and addr+1, so the last legal start is MEM_BYTES-2.
  assign in_range  = (txn_addr_reg <= AW'(MEM_BYTES - 2));
  assign in_access = (state_reg == ACCESS);
  assign in_resp   = (state_reg == RESP);

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          state_next      = ACCESS;
          last_grant_next = arb_grant;
          grant_en        = 1'b1;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      txn_port_reg   <= 1'b0;
      txn_wr_reg     <= 1'b0;
      txn_addr_reg   <= '0;
      txn_data_reg   <= '0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      if (grant_en) begin
        txn_port_reg <= arb_grant;
        txn_wr_reg   <= arb_grant ? Wr1    : Wr0;
        txn_addr_reg <= arb_grant ? Addr1  : Addr0;
        txn_data_reg <= arb_grant ? WData1 : WData0;
      end
      // Loads land in the winner's result register at the edge ending ACCESS.
      if (in_access && !txn_wr_reg && in_range) begin
        if (txn_port_reg) rdata1_reg <= MemRData;
        else              rdata0_reg <= MemRData;
      end
    end
  end

  assign MemAdresa = txn_addr_reg;
  assign MemWData  = txn_data_reg;
  assign MemWrite  = in_access &  txn_wr_reg & in_range;
  assign MemRead   = in_access & ~txn_wr_reg & in_range;

  assign Ack0   = in_resp & ~txn_port_reg;
  assign Ack1   = in_resp &  txn_port_reg;
  assign Err0   = Ack0 & ~in_range;
  assign Err1   = Ack1 & ~in_range;
  assign RData0 = rdata0_reg;
  assign RData1 = rdata1_reg;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a big-endian byte memory model.
module tb_data_memory_arbiter;

  logic        Clock, Reset;
  logic        Req0, Req1, Wr0, Wr1;
  logic [15:0] Addr0, Addr1, WData0, WData1;
  logic        Ack0, Ack1, Err0, Err1;
  logic [15:0] RData0, RData1;
  logic [15:0] MemAdresa, MemWData, MemRData;
  logic        MemWrite, MemRead;

  int vectors     = 0;
  int miscompares = 0;
  int both_ack_cnt    = 0;
  int both_strobe_cnt = 0;
  int memread_cnt     = 0;

  logic [7:0] mem [0:127] = '{default: 8'h00};

  data_memory_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
    .Err0(Err0), .Err1(Err1),
    .MemAdresa(MemAdresa), .MemWData(MemWData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemRData(MemRData)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Memory: combinational big-endian read, write on posedge.
  assign MemRData = {mem[MemAdresa[6:0]], mem[MemAdresa[6:0] + 7'd1]};
  always @(posedge Clock) begin
    if (MemWrite === 1'b1) begin
      mem[MemAdresa[6:0]]        <= MemWData[15:8];
      mem[MemAdresa[6:0] + 7'd1] <= MemWData[7:0];
    end
  end

  always @(negedge Clock) begin
    if (Ack0 === 1'b1 && Ack1 === 1'b1) both_ack_cnt++;
    if (MemWrite === 1'b1 && MemRead === 1'b1) both_strobe_cnt++;
    if (MemRead === 1'b1) memread_cnt++;
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Req0 = 0; Req1 = 0; Wr0 = 0; Wr1 = 0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
    tick;
    tick;
    vectors++;
    if ({Ack0, Ack1, Err0, Err1, MemWrite, MemRead} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000", {Ack0, Ack1, Err0, Err1, MemWrite, MemRead});
    end
    vectors++;
    if ({MemAdresa, MemWData, RData0, RData1} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_buses: got %h expected 0", {MemAdresa, MemWData, RData0, RData1});
    end
    Reset = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_store_load_p0;
    Req0 = 1; Wr0 = 1; Addr0 = 16'h0010; WData0 = 16'hBEEF;
    tick;
    vectors++;
    if ({Ack0, MemWrite, MemRead} !== 3'b010 || MemAdresa !== 16'h0010 || MemWData !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL p0_store_access: got ack/we/re=%b adr=%h wd=%h expected 010 0010 beef",
               {Ack0, MemWrite, MemRead}, MemAdresa, MemWData);
    end
    Addr0 = 16'h0040; WData0 = 16'h0BAD;
    tick;
    vectors++;
    if ({Ack0, Err0, MemWrite, Ack1} !== 4'b1000) begin
      miscompares++;
      $display("FAIL p0_store_resp: got ack0/err0/we/ack1=%b expected 1000", {Ack0, Err0, MemWrite, Ack1});
    end
    Req0 = 0;
    vectors++;
    if ({mem[16], mem[17]} !== 16'hBEEF || mem[64] !== 8'h00) begin
      miscompares++;
      $display("FAIL p0_store_mem: got %h%h (mem40=%h) expected beef (00)", mem[16], mem[17], mem[64]);
    end
    $display("txn port0 store addr=0010 data=beef");
    tick;
    vectors++;
    if (Ack0 !== 1'b0) begin
      miscompares++;
      $display("FAIL p0_ack_width: got %b expected 0", Ack0);
    end
    Req0 = 1; Wr0 = 0; Addr0 = 16'h0010;
    tick;
    vectors++;
    if ({Ack0, MemWrite, MemRead} !== 3'b001) begin
      miscompares++;
      $display("FAIL p0_load_access: got ack/we/re=%b expected 001", {Ack0, MemWrite, MemRead});
    end
    tick;
    vectors++;
    if (Ack0 !== 1'b1 || Err0 !== 1'b0 || RData0 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL p0_load_resp: got ack=%b err=%b rdata=%h expected 1 0 beef", Ack0, Err0, RData0);
    end
    Req0 = 0;
    $display("txn port0 load addr=0010 rdata=%h", RData0);
    tick;
    tick;
    vectors++;
    if (Ack0 !== 1'b0 || RData0 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL p0_rdata_hold: got ack=%b rdata=%h expected 0 beef", Ack0, RData0);
    end
  endtask

  task automatic test_contention;
    int ack_order [8];
    int n;
    int both_before;
    n = 0;
    Reset = 1; tick; Reset = 0;
    both_before = both_ack_cnt;
    Req0 = 1; Wr0 = 0; Addr0 = 16'h0010;
    Req1 = 1; Wr1 = 0; Addr1 = 16'h0010;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (Ack0 === 1'b1 && n < 8) begin ack_order[n] = 0; n++; $display("txn contention ack port0"); end
      if (Ack1 === 1'b1 && n < 8) begin ack_order[n] = 1; n++; $display("txn contention ack port1"); end
    end
    Req0 = 0; Req1 = 0;
    tick;
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL rr_count: got %0d acks expected 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i < n && ack_order[i] !== (i % 2)) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got port%0d expected port%0d", i, ack_order[i], i % 2);
      end
    end
    vectors++;
    if (both_ack_cnt !== both_before) begin
      miscompares++;
      $display("FAIL rr_dual_ack: got %0d cycles expected 0", both_ack_cnt - both_before);
    end
    vectors++;
    if (RData0 !== 16'hBEEF || RData1 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL rr_rdata: got %h %h expected beef beef", RData0, RData1);
    end
  endtask

  task automatic test_range_p1;
    int rd_before;
    Req1 = 1; Wr1 = 1; Addr1 = 16'h007E; WData1 = 16'h5AC3;
    tick;
    tick;
    Req1 = 0;
    vectors++;
    if (Ack1 !== 1'b1 || Err1 !== 1'b0 || mem[126] !== 8'h5A || mem[127] !== 8'hC3) begin
      miscompares++;
      $display("FAIL p1_store_7e: got ack=%b err=%b mem=%h%h expected 1 0 5ac3", Ack1, Err1, mem[126], mem[127]);
    end
    $display("txn port1 store addr=007e data=5ac3");
    tick;
    Req1 = 1; Wr1 = 0; Addr1 = 16'h007E;
    tick;
    tick;
    Req1 = 0;
    vectors++;
    if (Ack1 !== 1'b1 || Err1 !== 1'b0 || RData1 !== 16'h5AC3) begin
      miscompares++;
      $display("FAIL p1_load_7e: got ack=%b err=%b rdata=%h expected 1 0 5ac3", Ack1, Err1, RData1);
    end
    $display("txn port1 load addr=007e rdata=%h", RData1);
    tick;
    rd_before = memread_cnt;
    Req1 = 1; Wr1 = 0; Addr1 = 16'h007F;
    tick;
    vectors++;
    if (MemRead !== 1'b0 || Ack1 !== 1'b0) begin
      miscompares++;
      $display("FAIL p1_7f_access: got re=%b ack=%b expected 0 0", MemRead, Ack1);
    end
    tick;
    Req1 = 0;
    vectors++;
    if (Ack1 !== 1'b1 || Err1 !== 1'b1 || Err0 !== 1'b0 || RData1 !== 16'h5AC3) begin
      miscompares++;
      $display("FAIL p1_load_7f: got ack=%b err1=%b err0=%b rdata=%h expected 1 1 0 5ac3",
               Ack1, Err1, Err0, RData1);
    end
    $display("txn port1 load addr=007f err=%b", Err1);
    tick;
    vectors++;
    if (memread_cnt !== rd_before || Err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL p1_7f_noread: got reads=%0d err=%b expected 0 0", memread_cnt - rd_before, Err1);
    end
  endtask

  task automatic test_odd_addr;
    Req0 = 1; Wr0 = 1; Addr0 = 16'h0005; WData0 = 16'h1234;
    tick;
    tick;
    Req0 = 0;
    vectors++;
    if (Ack0 !== 1'b1 || mem[5] !== 8'h12 || mem[6] !== 8'h34) begin
      miscompares++;
      $display("FAIL odd_store: got ack=%b mem=%h%h expected 1 1234", Ack0, mem[5], mem[6]);
    end
    $display("txn port0 store addr=0005 data=1234");
    tick;
    Req0 = 1; Wr0 = 0;
    tick;
    tick;
    Req0 = 0;
    vectors++;
    if (Ack0 !== 1'b1 || Err0 !== 1'b0 || RData0 !== 16'h1234) begin
      miscompares++;
      $display("FAIL odd_load: got ack=%b err=%b rdata=%h expected 1 0 1234", Ack0, Err0, RData0);
    end
    $display("txn port0 load addr=0005 rdata=%h", RData0);
    tick;
  endtask

  task automatic test_reset_in_access;
    Req0 = 1; Wr0 = 0; Addr0 = 16'h0010;
    tick;
    vectors++;
    if (MemRead !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_access: got re=%b expected 1", MemRead);
    end
    Reset = 1;
    tick;
    Reset = 0; Req0 = 0;
    vectors++;
    if ({Ack0, Ack1, Err0, Err1, MemWrite, MemRead} !== 6'b0 ||
        {MemAdresa, MemWData, RData0, RData1} !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_in_access: got flags=%b buses=%h expected 000000 0",
               {Ack0, Ack1, Err0, Err1, MemWrite, MemRead}, {MemAdresa, MemWData, RData0, RData1});
    end
    tick;
    vectors++;
    if (Ack0 !== 1'b0 || MemRead !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_late_ack: got ack=%b re=%b expected 0 0", Ack0, MemRead);
    end
    $display("txn port0 load aborted by reset");
  endtask

  task automatic test_drop_req;
    Req1 = 1; Wr1 = 1; Addr1 = 16'h0020; WData1 = 16'h00AA;
    tick;
    Req1 = 0; Addr1 = 16'h0030; WData1 = 16'hFFFF;
    tick;
    vectors++;
    if (Ack1 !== 1'b1 || Err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ack: got ack=%b err=%b expected 1 0", Ack1, Err1);
    end
    vectors++;
    if (mem[32] !== 8'h00 || mem[33] !== 8'hAA || mem[48] !== 8'h00 || mem[49] !== 8'h00) begin
      miscompares++;
      $display("FAIL drop_mem: got %h%h (mem30=%h%h) expected 00aa (0000)", mem[32], mem[33], mem[48], mem[49]);
    end
    $display("txn port1 store addr=0020 data=00aa (req dropped)");
    tick;
    vectors++;
    if (Ack1 !== 1'b0 || both_strobe_cnt !== 0) begin
      miscompares++;
      $display("FAIL drop_idle: got ack=%b dual_strobe=%0d expected 0 0", Ack1, both_strobe_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_store_load_p0;
    test_contention;
    test_range_p1;
    test_odd_addr;
    test_reset_in_access;
    test_drop_req;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
